// File: rtl/ndro_check_pkg.sv
//------------------------------------------------------------------------------
// ndro_check_pkg
// Shared types and default constants for the NDRO readout checker.
//   fsm_state_e  : response-window FSM encoding (IDLE, EXP_ONE, EXP_ZERO)
//   DEF_RESP_WIN : default response window length in clk cycles
//   DEF_CNT_W    : default width of the saturating statistics counters
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ndro_check_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXP_ONE  = 2'd1,
    EXP_ZERO = 2'd2
  } fsm_state_e;

  localparam int unsigned DEF_RESP_WIN = 4;
  localparam int unsigned DEF_CNT_W    = 16;

endpackage : ndro_check_pkg

`default_nettype wire

// File: rtl/toggle_event_det.sv
//------------------------------------------------------------------------------
// toggle_event_det
// Converts a toggle-encoded pulse stream into a one-cycle event flag.
// Ports:
//   clk      in  : system clock
//   rst_n    in  : asynchronous active-low reset (previous value clears to 0)
//   toggle_i in  : toggle-encoded input stream
//   event_o  out : high in the cycle where toggle_i differs from last sample
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module toggle_event_det (
  input  logic clk,
  input  logic rst_n,
  input  logic toggle_i,
  output logic event_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= toggle_i;
    end
  end

  assign event_o = toggle_i ^ prev_q;

endmodule : toggle_event_det

`default_nettype wire

// File: rtl/ndro_readout_checker.sv
//------------------------------------------------------------------------------
// ndro_readout_checker
// Protocol checker for a basic NDRO cell. Tracks the expected stored bit from
// the set/reset pulse streams and checks the cell output after every read.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   set_t, reset_t    : toggle-encoded set / reset pulse streams
//   rd_t              : toggle-encoded read-clock pulse stream
//   out_t             : toggle-encoded NDRO output stream
//   state_o           : expected stored bit
//   busy_o            : a response window is open
//   err_missing_o     : strobe, expected 1-response did not arrive
//   err_spurious_o    : strobe, output toggle outside an expect-one window
//   err_conflict_o    : strobe, set+reset together or read inside a window
//   err_sticky_o      : OR of all strobes since reset
//   rd_count_o        : saturating count of read events
//   one_count_o       : saturating count of correctly observed 1-reads
//   err_count_o       : saturating count of error strobes
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ndro_readout_checker
  import ndro_check_pkg::*;
#(
  parameter int unsigned RESP_WIN = DEF_RESP_WIN,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_t,
  input  logic             reset_t,
  input  logic             rd_t,
  input  logic             out_t,
  output logic             state_o,
  output logic             busy_o,
  output logic             err_missing_o,
  output logic             err_spurious_o,
  output logic             err_conflict_o,
  output logic             err_sticky_o,
  output logic [CNT_W-1:0] rd_count_o,
  output logic [CNT_W-1:0] one_count_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int unsigned WIN_W = $clog2(RESP_WIN + 1);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(RESP_WIN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(1);

  // Adds 0..3 to a counter, sticking at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W + 1)'(b);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // Event detection
  logic set_evt;
  logic reset_evt;
  logic rd_evt;
  logic out_evt;

  toggle_event_det u_det_set   (.clk(clk), .rst_n(rst_n), .toggle_i(set_t),   .event_o(set_evt));
  toggle_event_det u_det_reset (.clk(clk), .rst_n(rst_n), .toggle_i(reset_t), .event_o(reset_evt));
  toggle_event_det u_det_rd    (.clk(clk), .rst_n(rst_n), .toggle_i(rd_t),    .event_o(rd_evt));
  toggle_event_det u_det_out   (.clk(clk), .rst_n(rst_n), .toggle_i(out_t),   .event_o(out_evt));

  // State
  fsm_state_e       fsm_q, fsm_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             state_q, state_d;
  logic             miss_q, miss_d;
  logic             spur_q, spur_d;
  logic             conf_q, conf_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] one_cnt_q, one_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             rd_inc;
  logic             one_inc;
  logic [1:0]       err_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      win_q     <= '0;
      state_q   <= 1'b0;
      miss_q    <= 1'b0;
      spur_q    <= 1'b0;
      conf_q    <= 1'b0;
      sticky_q  <= 1'b0;
      rd_cnt_q  <= '0;
      one_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      fsm_q     <= fsm_d;
      win_q     <= win_d;
      state_q   <= state_d;
      miss_q    <= miss_d;
      spur_q    <= spur_d;
      conf_q    <= conf_d;
      sticky_q  <= sticky_d;
      rd_cnt_q  <= rd_cnt_d;
      one_cnt_q <= one_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    win_d   = win_q;
    state_d = state_q;
    miss_d  = 1'b0;
    spur_d  = 1'b0;
    conf_d  = 1'b0;
    rd_inc  = 1'b0;
    one_inc = 1'b0;

    // Stored bit; simultaneous set and reset is ambiguous, so hold.
    if (set_evt && reset_evt) begin
      conf_d = 1'b1;
    end else if (set_evt) begin
      state_d = 1'b1;
    end else if (reset_evt) begin
      state_d = 1'b0;
    end

    if (rd_evt) begin
      // A read (re)opens the window using the pre-update stored bit; an
      // output toggle in this same cycle is judged against the new window.
      rd_inc = 1'b1;
      win_d  = WIN_LOAD;
      if (fsm_q != IDLE) begin
        conf_d = 1'b1;
      end
      if (fsm_q == EXP_ONE) begin
        miss_d = 1'b1;
      end
      if (state_q) begin
        if (out_evt) begin
          one_inc = 1'b1;
          fsm_d   = IDLE;
        end else begin
          fsm_d = EXP_ONE;
        end
      end else begin
        fsm_d = EXP_ZERO;
        if (out_evt) begin
          spur_d = 1'b1;
        end
      end
    end else begin
      case (fsm_q)
        IDLE: begin
          if (out_evt) begin
            spur_d = 1'b1;
          end
        end
        EXP_ONE: begin
          if (out_evt) begin
            one_inc = 1'b1;
            fsm_d   = IDLE;
          end else if (win_q <= WIN_LAST) begin
            miss_d = 1'b1;
            fsm_d  = IDLE;
          end else begin
            win_d = win_q - WIN_LAST;
          end
        end
        EXP_ZERO: begin
          if (out_evt) begin
            spur_d = 1'b1;
          end
          if (win_q <= WIN_LAST) begin
            fsm_d = IDLE;
          end else begin
            win_d = win_q - WIN_LAST;
          end
        end
        default: begin
          fsm_d = IDLE;
        end
      endcase
    end

    err_sum   = {1'b0, miss_d} + {1'b0, spur_d} + {1'b0, conf_d};
    sticky_d  = sticky_q | miss_d | spur_d | conf_d;
    rd_cnt_d  = sat_add(rd_cnt_q,  {1'b0, rd_inc});
    one_cnt_d = sat_add(one_cnt_q, {1'b0, one_inc});
    err_cnt_d = sat_add(err_cnt_q, err_sum);
  end

  assign state_o        = state_q;
  assign busy_o         = (fsm_q != IDLE);
  assign err_missing_o  = miss_q;
  assign err_spurious_o = spur_q;
  assign err_conflict_o = conf_q;
  assign err_sticky_o   = sticky_q;
  assign rd_count_o     = rd_cnt_q;
  assign one_count_o    = one_cnt_q;
  assign err_count_o    = err_cnt_q;

endmodule : ndro_readout_checker

`default_nettype wire

// File: tb/tb_ndro_readout_checker.sv
`default_nettype none

module tb_ndro_readout_checker;

  localparam int RW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          set_t = 1'b0;
  logic          reset_t = 1'b0;
  logic          rd_t = 1'b0;
  logic          out_t = 1'b0;
  logic          state_o;
  logic          busy_o;
  logic          err_missing_o;
  logic          err_spurious_o;
  logic          err_conflict_o;
  logic          err_sticky_o;
  logic [CW-1:0] rd_count_o;
  logic [CW-1:0] one_count_o;
  logic [CW-1:0] err_count_o;

  int n_pass = 0;
  int n_total = 0;

  ndro_readout_checker #(.RESP_WIN(RW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .set_t          (set_t),
    .reset_t        (reset_t),
    .rd_t           (rd_t),
    .out_t          (out_t),
    .state_o        (state_o),
    .busy_o         (busy_o),
    .err_missing_o  (err_missing_o),
    .err_spurious_o (err_spurious_o),
    .err_conflict_o (err_conflict_o),
    .err_sticky_o   (err_sticky_o),
    .rd_count_o     (rd_count_o),
    .one_count_o    (one_count_o),
    .err_count_o    (err_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_t = 1'b0; reset_t = 1'b0; rd_t = 1'b0; out_t = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (state_o !== 1'b0) $display("FAIL rst_state: got %b want 0", state_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else n_pass++;
    n_total++;
    if ({err_missing_o, err_spurious_o, err_conflict_o, err_sticky_o} !== 4'b0000)
      $display("FAIL rst_errs: got %b want 0000", {err_missing_o, err_spurious_o, err_conflict_o, err_sticky_o});
    else n_pass++;
    n_total++;
    if ({rd_count_o, one_count_o, err_count_o} !== '0)
      $display("FAIL rst_counts: got %h/%h/%h want 0/0/0", rd_count_o, one_count_o, err_count_o);
    else n_pass++;
  endtask

  task automatic test_standard();
    logic [3:0] exp_state;
    int busy_cycles;
    logic err_seen;
    exp_state = 4'b0011; // bit i = state after event i (set, set, reset, reset)
    busy_cycles = 0;
    err_seen = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 2) set_t = ~set_t; else reset_t = ~reset_t;
      step(1);
      n_total++;
      if (state_o !== exp_state[i]) $display("FAIL std_state%0d: got %b want %b", i, state_o, exp_state[i]);
      else n_pass++;
    end
    rd_t = ~rd_t;
    step(1);
    n_total++; if (rd_count_o !== 4'd1) $display("FAIL std_rdcnt: got %0d want 1", rd_count_o); else n_pass++;
    for (int k = 0; k < RW + 3; k++) begin
      if (busy_o === 1'b1) busy_cycles++;
      if (err_missing_o || err_spurious_o || err_conflict_o) err_seen = 1'b1;
      step(1);
    end
    n_total++; if (busy_cycles != RW) $display("FAIL std_busy_len: got %0d want %0d", busy_cycles, RW); else n_pass++;
    n_total++; if (err_seen !== 1'b0) $display("FAIL std_no_strobe: got %b want 0", err_seen); else n_pass++;
    n_total++; if (err_count_o !== 4'd0) $display("FAIL std_errcnt: got %0d want 0", err_count_o); else n_pass++;
  endtask

  task automatic test_read_one();
    do_reset();
    set_t = ~set_t;
    step(1);
    rd_t = ~rd_t;
    step(1);
    step(1);
    out_t = ~out_t;
    step(1);
    n_total++; if (one_count_o !== 4'd1) $display("FAIL r1_onecnt: got %0d want 1", one_count_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL r1_busy: got %b want 0", busy_o); else n_pass++;
    step(RW + 2);
    n_total++; if (err_sticky_o !== 1'b0) $display("FAIL r1_sticky: got %b want 0", err_sticky_o); else n_pass++;
    // Output toggle in the same cycle as the read is a valid 1-response.
    rd_t = ~rd_t;
    out_t = ~out_t;
    step(1);
    n_total++; if (one_count_o !== 4'd2) $display("FAIL r1_same_onecnt: got %0d want 2", one_count_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL r1_same_busy: got %b want 0", busy_o); else n_pass++;
    step(1);
    n_total++;
    if ({err_sticky_o, rd_count_o} !== {1'b0, 4'd2})
      $display("FAIL r1_same_sticky_rd: got %b/%0d want 0/2", err_sticky_o, rd_count_o);
    else n_pass++;
  endtask

  task automatic test_missing();
    do_reset();
    set_t = ~set_t;
    step(1);
    rd_t = ~rd_t;
    step(1);
    step(RW - 1);
    n_total++;
    if ({err_missing_o, busy_o} !== 2'b01) $display("FAIL miss_early: got miss/busy %b want 01", {err_missing_o, busy_o});
    else n_pass++;
    step(1);
    n_total++; if (err_missing_o !== 1'b1) $display("FAIL miss_strobe: got %b want 1", err_missing_o); else n_pass++;
    n_total++; if (err_count_o !== 4'd1) $display("FAIL miss_errcnt: got %0d want 1", err_count_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL miss_busy: got %b want 0", busy_o); else n_pass++;
    step(1);
    n_total++; if (err_missing_o !== 1'b0) $display("FAIL miss_one_cycle: got %b want 0", err_missing_o); else n_pass++;
    n_total++;
    if ({err_sticky_o, err_count_o} !== {1'b1, 4'd1})
      $display("FAIL miss_sticky_cnt: got %b/%0d want 1/1", err_sticky_o, err_count_o);
    else n_pass++;
  endtask

  task automatic test_spurious();
    do_reset();
    out_t = ~out_t;
    step(1);
    n_total++; if (err_spurious_o !== 1'b1) $display("FAIL spur_idle: got %b want 1", err_spurious_o); else n_pass++;
    rd_t = ~rd_t;
    step(1);
    n_total++; if (err_spurious_o !== 1'b0) $display("FAIL spur_gap: got %b want 0", err_spurious_o); else n_pass++;
    out_t = ~out_t;
    step(1);
    n_total++; if (err_spurious_o !== 1'b1) $display("FAIL spur_expzero: got %b want 1", err_spurious_o); else n_pass++;
    n_total++; if (err_count_o !== 4'd2) $display("FAIL spur_errcnt: got %0d want 2", err_count_o); else n_pass++;
    step(RW + 2);
    n_total++;
    if ({busy_o, err_count_o, one_count_o} !== {1'b0, 4'd2, 4'd0})
      $display("FAIL spur_end: got busy/err/one %b/%0d/%0d want 0/2/0", busy_o, err_count_o, one_count_o);
    else n_pass++;
  endtask

  task automatic test_conflict();
    do_reset();
    set_t = ~set_t;
    step(1);
    set_t = ~set_t;
    reset_t = ~reset_t;
    step(1);
    n_total++; if (state_o !== 1'b1) $display("FAIL conf_state: got %b want 1", state_o); else n_pass++;
    n_total++;
    if ({err_conflict_o, err_count_o} !== {1'b1, 4'd1})
      $display("FAIL conf_sr: got conf/err %b/%0d want 1/1", err_conflict_o, err_count_o);
    else n_pass++;
    step(1);
    rd_t = ~rd_t;
    step(1);
    rd_t = ~rd_t;
    step(1);
    n_total++;
    if ({err_conflict_o, err_missing_o} !== 2'b11)
      $display("FAIL conf_rr_strobes: got conf/miss %b want 11", {err_conflict_o, err_missing_o});
    else n_pass++;
    n_total++; if (err_count_o !== 4'd3) $display("FAIL conf_rr_errcnt: got %0d want 3", err_count_o); else n_pass++;
    n_total++; if (rd_count_o !== 4'd2) $display("FAIL conf_rr_rdcnt: got %0d want 2", rd_count_o); else n_pass++;
    out_t = ~out_t;
    step(1);
    n_total++;
    if ({one_count_o, busy_o, err_count_o} !== {4'd1, 1'b0, 4'd3})
      $display("FAIL conf_rearm: got one/busy/err %0d/%b/%0d want 1/0/3", one_count_o, busy_o, err_count_o);
    else n_pass++;
  endtask

  task automatic test_reset_handling();
    do_reset();
    set_t = ~set_t;
    step(1);
    rd_t = ~rd_t;
    step(2);
    n_total++; if (busy_o !== 1'b1) $display("FAIL rh_busy_pre: got %b want 1", busy_o); else n_pass++;
    rst_n = 1'b0;
    set_t = 1'b0; rd_t = 1'b0;
    #1;
    n_total++;
    if ({state_o, busy_o, err_sticky_o, rd_count_o} !== '0)
      $display("FAIL rh_async_clear: got state/busy/sticky/rd %b/%b/%b/%0d want 0", state_o, busy_o, err_sticky_o, rd_count_o);
    else n_pass++;
    step(1);
    rst_n = 1'b1;
    step(RW + 2);
    n_total++;
    if ({err_missing_o, err_sticky_o, err_count_o, busy_o} !== '0)
      $display("FAIL rh_no_strobe: got miss/sticky/err/busy %b/%b/%0d/%b want 0", err_missing_o, err_sticky_o, err_count_o, busy_o);
    else n_pass++;
    for (int i = 0; i < 14; i++) begin
      rd_t = ~rd_t;
      step(RW + 1);
    end
    n_total++; if (rd_count_o !== 4'd14) $display("FAIL rh_rd14: got %0d want 14", rd_count_o); else n_pass++;
    for (int i = 0; i < (1 << CW) + 3 - 14; i++) begin
      rd_t = ~rd_t;
      step(RW + 1);
    end
    n_total++; if (rd_count_o !== 4'hF) $display("FAIL rh_rd_sat: got %0d want 15", rd_count_o); else n_pass++;
    n_total++; if (err_count_o !== 4'd0) $display("FAIL rh_rd_errcnt: got %0d want 0", err_count_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_standard();
    test_read_one();
    test_missing();
    test_spurious();
    test_conflict();
    test_reset_handling();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ndro_readout_checker

`default_nettype wire
